// File: rtl/mig_ui_adapter_if.sv
`default_nettype none
// ============================================================================
// mig_ui_adapter_if : upstream command bus and MIG app_* user-interface bundles
// Rev 1.0
// ============================================================================

// Upstream single-word command stream; member names are from the adapter's view.
interface mig_ui_adapter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  en_i;
    logic                  w_en_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic [DATA_W/8-1:0]   strb_i;
    logic                  ready_o;
    logic                  w_ready_o;
    logic                  valid_o;
    logic [DATA_W-1:0]     data_o;

    modport master (
        output en_i, w_en_i, addr_i, data_i, strb_i,
        input  ready_o, w_ready_o, valid_o, data_o
    );
    modport slave (
        input  en_i, w_en_i, addr_i, data_i, strb_i,
        output ready_o, w_ready_o, valid_o, data_o
    );
endinterface

// MIG native user interface; the adapter is the master side.
interface mig_app_if #(
    parameter int APP_DATA_W = 128,
    parameter int APP_ADDR_W = 27
);
    logic                    app_en_o;
    logic [2:0]              app_cmd_o;
    logic [APP_ADDR_W-1:0]   app_addr_o;
    logic                    app_rdy_i;
    logic [APP_DATA_W-1:0]   app_wdf_data_o;
    logic [APP_DATA_W/8-1:0] app_wdf_mask_o;
    logic                    app_wdf_wren_o;
    logic                    app_wdf_end_o;
    logic                    app_wdf_rdy_i;
    logic [APP_DATA_W-1:0]   app_rd_data_i;
    logic                    app_rd_data_valid_i;
    logic                    app_rd_data_end_i;

    modport master (
        output app_en_o, app_cmd_o, app_addr_o,
               app_wdf_data_o, app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o,
        input  app_rdy_i, app_wdf_rdy_i,
               app_rd_data_i, app_rd_data_valid_i, app_rd_data_end_i
    );
    modport slave (
        input  app_en_o, app_cmd_o, app_addr_o,
               app_wdf_data_o, app_wdf_mask_o, app_wdf_wren_o, app_wdf_end_o,
        output app_rdy_i, app_wdf_rdy_i,
               app_rd_data_i, app_rd_data_valid_i, app_rd_data_end_i
    );
endinterface

`default_nettype wire

// File: rtl/mig_ui_adapter.sv
`default_nettype none
// ============================================================================
// mig_ui_adapter : one-at-a-time bridge from a single-word command stream to MIG
//                  app_* UI with lane select/mask and read-lane extraction
// Rev 1.0
// ============================================================================
module mig_ui_adapter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int APP_DATA_W = 128,
    parameter int APP_ADDR_W = 27,
    parameter int DQ_W       = 16
) (
    input  wire                ui_clk_i,
    input  wire                ui_reset_ni,
    input  wire                init_calib_complete_i,
    mig_ui_adapter_if.slave    up,
    mig_app_if.master          app
);
    localparam int STRB_W     = DATA_W / 8;
    localparam int APP_STRB_W = APP_DATA_W / 8;
    localparam int LANES      = APP_DATA_W / DATA_W;
    localparam int LANE_LO    = $clog2(STRB_W);
    localparam int LANE_W     = $clog2(LANES);
    localparam int ADDR_SH    = $clog2(DQ_W / 8);

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RD_CMD  = 2'd2,
        S_RD_DATA = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    app_en_q;
    logic [2:0]              app_cmd_q;
    logic [APP_ADDR_W-1:0]   app_addr_q;
    logic [APP_DATA_W-1:0]   wdf_data_q;
    logic [APP_STRB_W-1:0]   wdf_mask_q;
    logic                    wdf_wren_q;
    logic [LANE_W-1:0]       lane_q;
    logic                    valid_q;
    logic [DATA_W-1:0]       data_q;

    logic                    ready_d;
    logic                    accept_d;
    logic [LANE_W-1:0]       lane_d;
    logic [ADDR_W-1:0]       addr_sh_d;
    logic [APP_ADDR_W-1:0]   app_addr_d;
    logic [APP_STRB_W-1:0]   wdf_mask_d;
    logic                    write_done_d;

    // Reset is folded in so ready stays low while the block is held in reset.
    assign ready_d    = (state_q == S_IDLE) && init_calib_complete_i && ui_reset_ni;
    assign accept_d   = up.en_i && ready_d;
    assign lane_d     = up.addr_i[LANE_LO +: LANE_W];
    assign addr_sh_d  = up.addr_i >> ADDR_SH;
    assign app_addr_d = {addr_sh_d[APP_ADDR_W-1:3], 3'b000};

    // A WRITE finishes once each handshake is either already done or completing now.
    assign write_done_d = (!app_en_q || app.app_rdy_i) && (!wdf_wren_q || app.app_wdf_rdy_i);

    always_comb begin
        wdf_mask_d = '1;
        wdf_mask_d[lane_d*STRB_W +: STRB_W] = ~up.strb_i;
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_ni) begin
        if (!ui_reset_ni) begin
            state_q    <= S_IDLE;
            app_en_q   <= 1'b0;
            app_cmd_q  <= 3'b000;
            app_addr_q <= '0;
            wdf_data_q <= '0;
            wdf_mask_q <= '1;
            wdf_wren_q <= 1'b0;
            lane_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        app_en_q   <= 1'b1;
                        app_addr_q <= app_addr_d;
                        lane_q     <= lane_d;
                        if (up.w_en_i) begin
                            app_cmd_q  <= CMD_WRITE;
                            wdf_data_q <= {LANES{up.data_i}};
                            wdf_mask_q <= wdf_mask_d;
                            wdf_wren_q <= 1'b1;
                            state_q    <= S_WRITE;
                        end else begin
                            app_cmd_q  <= CMD_READ;
                            state_q    <= S_RD_CMD;
                        end
                    end
                end
                S_WRITE: begin
                    if (app.app_rdy_i) begin
                        app_en_q <= 1'b0;
                    end
                    if (app.app_wdf_rdy_i) begin
                        wdf_wren_q <= 1'b0;
                    end
                    if (write_done_d) begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD_CMD: begin
                    if (app.app_rdy_i) begin
                        app_en_q <= 1'b0;
                        state_q  <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (app.app_rd_data_valid_i) begin
                        data_q  <= app.app_rd_data_i[lane_q*DATA_W +: DATA_W];
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign up.ready_o   = ready_d;
    assign up.w_ready_o = ready_d;
    assign up.valid_o   = valid_q;
    assign up.data_o    = data_q;

    assign app.app_en_o       = app_en_q;
    assign app.app_cmd_o      = app_cmd_q;
    assign app.app_addr_o     = app_addr_q;
    assign app.app_wdf_data_o = wdf_data_q;
    assign app.app_wdf_mask_o = wdf_mask_q;
    assign app.app_wdf_wren_o = wdf_wren_q;
    assign app.app_wdf_end_o  = wdf_wren_q;

    // Single-beat reads make the end flag redundant; ignored address bits land here too.
    logic unused_ok;
    assign unused_ok = &{1'b0, addr_sh_d, up.addr_i, app.app_rd_data_end_i};

endmodule

`default_nettype wire

// File: tb/tb_mig_ui_adapter.sv
`default_nettype none
// ============================================================================
// tb_mig_ui_adapter : randomized transaction bench with an arithmetic reference model
// Rev 1.0
// ============================================================================
module tb_mig_ui_adapter;
    logic clk = 1'b0;
    logic rst_n;
    logic calib;
    int   n_vec;
    int   n_err;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mig_ui_adapter_if #(.DATA_W(32), .ADDR_W(32)) up ();
    mig_app_if #(.APP_DATA_W(128), .APP_ADDR_W(27)) app ();

    mig_ui_adapter #(
        .DATA_W(32), .ADDR_W(32), .APP_DATA_W(128), .APP_ADDR_W(27), .DQ_W(16)
    ) dut (
        .ui_clk_i              (clk),
        .ui_reset_ni           (rst_n),
        .init_calib_complete_i (calib),
        .up                    (up),
        .app                   (app)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: byte address -> 16-bit DQ units, BL8-aligned, 27 bits.
    function automatic logic [26:0] m_app_addr(input logic [31:0] a);
        longint v;
        v = (longint'(a) / 2) % (longint'(1) << 27);
        v = v - (v % 8);
        return 27'(v);
    endfunction

    function automatic int m_lane(input logic [31:0] a);
        return int'((a / 4) % 4);
    endfunction

    function automatic logic [15:0] m_mask(input logic [31:0] a, input logic [3:0] s);
        logic [15:0] m;
        for (int b = 0; b < 16; b++) m[b] = !(((b / 4) == m_lane(a)) && s[b % 4]);
        return m;
    endfunction

    function automatic logic [127:0] m_wdata(input logic [31:0] d);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = d;
        return r;
    endfunction

    function automatic logic [31:0] m_rword(input logic [31:0] a, input logic [127:0] beat);
        logic [127:0] sh;
        sh = beat >> (32 * m_lane(a));
        return sh[31:0];
    endfunction

    task automatic drive_garbage_upstream();
        up.en_i   = ($urandom_range(1, 0) != 0);
        up.w_en_i = ($urandom_range(1, 0) != 0);
        up.addr_i = $urandom;
        up.data_i = $urandom;
        up.strb_i = 4'($urandom);
    endtask

    task automatic check_reset_outputs(input string ph);
        check_eq({ph, "_ready"},   up.ready_o, 0);
        check_eq({ph, "_wready"},  up.w_ready_o, 0);
        check_eq({ph, "_valid"},   up.valid_o, 0);
        check_eq({ph, "_data"},    up.data_o, 0);
        check_eq({ph, "_app_en"},  app.app_en_o, 0);
        check_eq({ph, "_app_cmd"}, app.app_cmd_o, 0);
        check_eq({ph, "_app_addr"}, app.app_addr_o, 0);
        check_eq({ph, "_wdata"},   app.app_wdf_data_o, 0);
        check_eq({ph, "_wmask"},   app.app_wdf_mask_o, 16'hFFFF);
        check_eq({ph, "_wren"},    app.app_wdf_wren_o, 0);
        check_eq({ph, "_wend"},    app.app_wdf_end_o, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // Negative delays mean random per-cycle handshakes and wobbling calibration.
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [127:0] beat, input int gate,
                           input bit spur, input int cmd_dly, input int dat_dly, input int rd_dly);
        logic [26:0]  e_addr;
        logic [127:0] e_wd;
        logic [15:0]  e_mask;
        logic [31:0]  e_rw;
        bit cmd_done, dat_done, ar, dr;
        int k, n;
        e_addr = m_app_addr(a);
        e_wd   = m_wdata(d);
        e_mask = m_mask(a, s);
        e_rw   = m_rword(a, beat);
        if (spur) begin
            app.app_rd_data_valid_i = 1'b1;
            app.app_rd_data_i       = ~beat;
            @(negedge clk);
            app.app_rd_data_valid_i = 1'b0;
            check_eq("spur_valid", up.valid_o, 0);
            check_eq("spur_hold", up.data_o, last_rd);
        end
        up.en_i = 1'b1; up.w_en_i = wr; up.addr_i = a; up.data_i = d; up.strb_i = s;
        if (gate > 0) begin
            calib = 1'b0;
            for (int i = 0; i < gate; i++) begin
                #1;
                check_eq("gate_ready", up.ready_o, 0);
                check_eq("gate_wready", up.w_ready_o, 0);
                @(negedge clk);
                check_eq("gate_app_en", app.app_en_o, 0);
            end
            calib = 1'b1;
        end
        #1;
        check_eq("accept_ready", up.ready_o, 1);
        check_eq("accept_wready", up.w_ready_o, 1);
        @(negedge clk);

        cmd_done = 1'b0;
        dat_done = !wr;
        k = 0;
        do begin
            check_eq("hs_ready", up.ready_o, 0);
            check_eq("hs_valid", up.valid_o, 0);
            check_eq("hs_data_hold", up.data_o, last_rd);
            check_eq("hs_app_en", app.app_en_o, !cmd_done);
            if (!cmd_done) begin
                check_eq("hs_app_cmd", app.app_cmd_o, wr ? 3'b000 : 3'b001);
                check_eq("hs_app_addr", app.app_addr_o, e_addr);
            end
            check_eq("hs_wren", app.app_wdf_wren_o, !dat_done);
            check_eq("hs_wend", app.app_wdf_end_o, !dat_done);
            if (!dat_done) begin
                check_eq("hs_wdata", app.app_wdf_data_o, e_wd);
                check_eq("hs_wmask", app.app_wdf_mask_o, e_mask);
            end
            ar = (cmd_dly < 0) ? ($urandom_range(1, 0) != 0) : (k >= cmd_dly);
            dr = (dat_dly < 0) ? ($urandom_range(1, 0) != 0) : (k >= dat_dly);
            app.app_rdy_i           = ar;
            app.app_wdf_rdy_i       = dr;
            app.app_rd_data_valid_i = ($urandom_range(3, 0) == 0);
            app.app_rd_data_i       = {$urandom, $urandom, $urandom, $urandom};
            drive_garbage_upstream();
            if (cmd_dly < 0) calib = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (ar) cmd_done = 1'b1;
            if (dr && wr) dat_done = 1'b1;
            k++;
            if (k > 64) begin
                check_eq("hs_timeout", k, 0);
                break;
            end
        end while (!(cmd_done && dat_done));
        app.app_rd_data_valid_i = 1'b0;

        if (!wr) begin
            n = (rd_dly < 0) ? int'($urandom_range(3, 0)) : rd_dly;
            for (int i = 0; i < n; i++) begin
                check_eq("rdw_valid", up.valid_o, 0);
                check_eq("rdw_ready", up.ready_o, 0);
                check_eq("rdw_app_en", app.app_en_o, 0);
                app.app_rdy_i = ($urandom_range(1, 0) != 0);
                drive_garbage_upstream();
                @(negedge clk);
            end
            app.app_rd_data_valid_i = 1'b1;
            app.app_rd_data_end_i   = 1'b1;
            app.app_rd_data_i       = beat;
            drive_garbage_upstream();
            @(negedge clk);
            app.app_rd_data_valid_i = 1'b0;
            app.app_rd_data_end_i   = 1'b0;
            app.app_rd_data_i       = ~beat;
            last_rd = e_rw;
            check_eq("rd_valid", up.valid_o, 1);
            check_eq("rd_data", up.data_o, e_rw);
        end
        up.en_i = 1'b0;
        calib   = 1'b1;
        #1;
        check_eq("done_ready", up.ready_o, 1);
        check_eq("done_app_en", app.app_en_o, 0);
        check_eq("done_wren", app.app_wdf_wren_o, 0);
        if (!wr) begin
            @(negedge clk);
            check_eq("rd_pulse_end", up.valid_o, 0);
            check_eq("rd_data_hold", up.data_o, last_rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, required completion before 2ms");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        last_rd = '0;
        rst_n = 1'b0;
        calib = 1'b1;
        up.en_i = 1'b0; up.w_en_i = 1'b0; up.addr_i = '0; up.data_i = '0; up.strb_i = '0;
        app.app_rdy_i = 1'b0; app.app_wdf_rdy_i = 1'b0;
        app.app_rd_data_i = '0; app.app_rd_data_valid_i = 1'b0; app.app_rd_data_end_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", up.ready_o, 1);

        // Write to lane 2 with low half-word strobes, both handshakes immediate.
        run_txn(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 4'b0011, '0, 0, 1'b0, 0, 0, 0);
        // Calibration gating before acceptance.
        run_txn(1'b1, 32'h0000_1234, 32'hCAFE_F00D, 4'b1111, '0, 3, 1'b0, 0, 0, 0);
        // Split handshake: command at once, write data after 3 stalled cycles.
        run_txn(1'b1, 32'h0001_00A0, 32'h1234_5678, 4'b1010, '0, 0, 1'b0, 0, 3, 0);
        // Read lane 1 with a 2-cycle command stall.
        run_txn(1'b0, 32'h0000_0004, '0, '0, 128'h33333333_22222222_11111111_00000000,
                0, 1'b0, 2, 0, 1);
        // Spurious read return in idle, then back-to-back write and read.
        run_txn(1'b1, 32'h0000_004C, 32'hA5A5_5A5A, 4'b1100, '0, 0, 1'b1, 0, 0, 0);
        run_txn(1'b0, 32'h0000_004C, '0, '0, {$urandom, $urandom, $urandom, $urandom},
                0, 1'b1, 0, 0, 0);

        // Reset in the middle of a stalled write abandons it.
        up.en_i = 1'b1; up.w_en_i = 1'b1; up.addr_i = 32'h0000_0010;
        up.data_i = 32'h0BAD_F00D; up.strb_i = 4'hF;
        app.app_rdy_i = 1'b0; app.app_wdf_rdy_i = 1'b0;
        @(negedge clk);
        up.en_i = 1'b0;
        check_eq("rstw_pre_app_en", app.app_en_o, 1);
        check_eq("rstw_pre_wren", app.app_wdf_wren_o, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        app.app_rdy_i = 1'b1; app.app_wdf_rdy_i = 1'b1;
        last_rd = '0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rstw_idle_ready", up.ready_o, 1);
            check_eq("rstw_no_replay_en", app.app_en_o, 0);
            check_eq("rstw_no_replay_wren", app.app_wdf_wren_o, 0);
        end

        for (int t = 0; t < 200; t++) begin
            run_txn(($urandom_range(1, 0) != 0), $urandom, $urandom, 4'($urandom),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0,
                    ($urandom_range(3, 0) == 0), -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
